// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that serialises requester words into one shared
// sequence detector and reports the detection count per word.
module seq_detect_scheduler #(
    parameter int NREQ = 4,
    parameter int WORD_W = 8,
    localparam int CW = $clog2(WORD_W + 1),
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   det_clear,
    output logic                   det_seq_in,
    input  logic                   det_out,
    output logic                   done,
    output logic [IW-1:0]          done_id,
    output logic [CW-1:0]          hit_count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        REPORT
    } state_t;

    state_t state;
    state_t state_nx;

    // High only in the first cycle after reset release; blocks grants
    // and keeps the detector clear until the first edge.
    logic rst_hold;

    logic [IW-1:0]     last_q;
    logic [IW-1:0]     id_q;
    logic [IW-1:0]     win;
    logic              any;
    int                arb_idx;
    logic [WORD_W-1:0] word_q;
    logic [CW-1:0]     bit_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     hit_q;
    logic              sample;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win = '0;
        any = 1'b0;
        arb_idx = 0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_idx = (int'(last_q) + i) % NREQ;
            if (!any && req[arb_idx]) begin
                any = 1'b1;
                win = IW'(arb_idx);
            end
        end
    end

    // Next state and all FSM-decoded outputs.
    always_comb begin
        state_nx   = state;
        gnt        = '0;
        det_clear  = rst_hold;
        det_seq_in = 1'b0;
        sample     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (any && !rst_hold) begin
                    gnt[win] = 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                det_clear = 1'b1;
                state_nx  = SHIFT;
            end
            SHIFT: begin
                det_seq_in = word_q[WORD_W-1];
                // Cycle 0 still sees the detector's cleared state.
                sample = (bit_q != '0);
                if (bit_q == CW'(WORD_W - 1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                sample   = 1'b1;
                state_nx = REPORT;
            end
            REPORT: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done_id   = id_q;
    assign hit_count = hit_q;

    // Saturating hit counter input.
    always_comb begin
        cnt_nx = cnt_q;
        if (sample && det_out && (cnt_q != CW'(WORD_W))) begin
            cnt_nx = cnt_q + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rst_hold <= 1'b1;
        end else begin
            state    <= state_nx;
            rst_hold <= 1'b0;
        end
    end

    // Job datapath: word capture, bit shifting, counting, result load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= IW'(NREQ - 1);
            id_q   <= '0;
            word_q <= '0;
            bit_q  <= '0;
            cnt_q  <= '0;
            hit_q  <= '0;
        end else begin
            cnt_q <= cnt_nx;
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        last_q <= win;
                        id_q   <= win;
                        word_q <= req_data[int'(win)*WORD_W +: WORD_W];
                        cnt_q  <= '0;
                    end
                end
                CLEAR: bit_q <= '0;
                SHIFT: begin
                    bit_q  <= bit_q + CW'(1);
                    word_q <= {word_q[WORD_W-2:0], 1'b0};
                end
                DRAIN: hit_q <= cnt_nx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler with a Moore overlapping "1011"
// detector model and an expected-result scoreboard.
module tb_seq_detect_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        det_clear;
    logic        det_seq_in;
    logic        det_out;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_count;

    int pass = 0;
    int total = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int hits;
    } exp_t;
    exp_t exp_q[$];

    seq_detect_scheduler #(.NREQ(4), .WORD_W(8)) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .busy(busy),
        .det_clear(det_clear),
        .det_seq_in(det_seq_in),
        .det_out(det_out),
        .done(done),
        .done_id(done_id),
        .hit_count(hit_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Moore detector for overlapping "1011": states 0..4, 4 = found.
    logic [2:0] ds;
    assign det_out = (ds == 3'd4);
    always @(posedge clock) begin
        if (reset || det_clear) ds <= 3'd0;
        else begin
            case (ds)
                3'd0: ds <= det_seq_in ? 3'd1 : 3'd0;
                3'd1: ds <= det_seq_in ? 3'd1 : 3'd2;
                3'd2: ds <= det_seq_in ? 3'd3 : 3'd0;
                3'd3: ds <= det_seq_in ? 3'd4 : 3'd2;
                default: ds <= det_seq_in ? 3'd1 : 3'd2;
            endcase
        end
    end

    function automatic int ref_hits(input logic [7:0] w);
        int n = 0;
        for (int j = 7; j >= 3; j--)
            if (w[j -: 4] == 4'b1011) n++;
        return (n > 8) ? 8 : n;
    endfunction

    // Scoreboard monitor: grant order, result, latency, clear pulses,
    // hit_count stability between done pulses.
    int t_gnt = 0;
    int clr_cnt = 0;
    int last_hit = 0;
    always @(negedge clock) begin
        if (reset) begin
            clr_cnt = 0;
            last_hit = 0;
        end else begin
            if (det_clear) clr_cnt++;
            if (|gnt) begin
                t_gnt = cyc;
                clr_cnt = 0;
                total++;
                if (exp_q.size() == 0)
                    $display("FAIL sb_gnt unexpected gnt=%b", gnt);
                else if (gnt !== 4'(1 << exp_q[0].id))
                    $display("FAIL sb_gnt got %b want id %0d", gnt, exp_q[0].id);
                else pass++;
            end
            if (done) begin
                exp_t e;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_done unexpected done id=%0d", done_id);
                end else begin
                    e = exp_q.pop_front();
                    if (done_id !== 2'(e.id) || hit_count !== 4'(e.hits))
                        $display("FAIL sb_result got id=%0d hits=%0d want id=%0d hits=%0d",
                                 done_id, hit_count, e.id, e.hits);
                    else pass++;
                    total++;
                    if (cyc - t_gnt != 11)
                        $display("FAIL sb_latency got %0d want 11", cyc - t_gnt);
                    else pass++;
                    total++;
                    if (clr_cnt != 1)
                        $display("FAIL sb_clear_pulses got %0d want 1", clr_cnt);
                    else pass++;
                end
                last_hit = hit_count;
            end else begin
                total++;
                if (hit_count !== 4'(last_hit))
                    $display("FAIL hit_stable got %0d want %0d", hit_count, last_hit);
                else pass++;
            end
        end
    end

    task automatic submit(input int id, input logic [7:0] w);
        exp_q.push_back('{id: id, hits: ref_hits(w)});
        @(posedge clock); #1;
        req_data[id*8 +: 8] = w;
        req[id] = 1'b1;
    endtask

    task automatic wait_gnt(output bit got, output int at);
        got = 1'b0;
        at = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (|gnt) begin
                got = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic wait_done(output bit got, output int at);
        got = 1'b0;
        at = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic drop(input int id);
        @(posedge clock); #1;
        req[id] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total += 7;
        if (gnt !== 4'b0) $display("FAIL rst_gnt got %b want 0", gnt); else pass++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass++;
        if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else pass++;
        if (done_id !== 2'd0) $display("FAIL rst_done_id got %0d want 0", done_id); else pass++;
        if (hit_count !== 4'd0) $display("FAIL rst_hits got %0d want 0", hit_count); else pass++;
        if (det_seq_in !== 1'b0) $display("FAIL rst_seq_in got %b want 0", det_seq_in); else pass++;
        if (det_clear !== 1'b1) $display("FAIL rst_clear got %b want 1", det_clear); else pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (det_clear !== 1'b1) $display("FAIL rel_clear got %b want 1", det_clear); else pass++;
        @(negedge clock);
        total += 2;
        if (det_clear !== 1'b0) $display("FAIL idle_clear got %b want 0", det_clear); else pass++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] w[4] = '{8'hBB, 8'h0B, 8'hB6, 8'h2D};
        int gc[5];
        int n = 0;
        int td;
        bit got;
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{id: i % 4, hits: ref_hits(w[i % 4])});
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = w[i];
        req = 4'hF;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clock);
            total++;
            if (busy !== (gnt == 4'b0))
                $display("FAIL rr_busy got %b gnt=%b", busy, gnt);
            else pass++;
            if (|gnt) begin
                total++;
                if (gnt !== 4'(1 << (n % 4)))
                    $display("FAIL rr_order got %b want %b", gnt, 4'(1 << (n % 4)));
                else pass++;
                gc[n] = cyc;
                n++;
            end
        end
        total++;
        if (n != 5) $display("FAIL rr_count got %0d want 5", n); else pass++;
        @(posedge clock); #1;
        req = 4'b0;
        for (int i = 1; i < n; i++) begin
            total++;
            if (gc[i] - gc[i-1] != 12)
                $display("FAIL rr_spacing got %0d want 12", gc[i] - gc[i-1]);
            else pass++;
        end
        wait_done(got, td);
        total++;
        if (!got) $display("FAIL rr_done got timeout want done"); else pass++;
    endtask

    task automatic test_single();
        int t0, tg, td;
        bit got;
        submit(0, 8'b1011_1011);
        t0 = cyc;
        wait_gnt(got, tg);
        total += 2;
        if (!got || tg != t0) $display("FAIL single_gnt_time got %0d want %0d", tg, t0); else pass++;
        if (gnt !== 4'b0001) $display("FAIL single_gnt got %b want 0001", gnt); else pass++;
        drop(0);
        wait_done(got, td);
        total += 3;
        if (!got || td - tg != 11) $display("FAIL single_latency got %0d want 11", td - tg); else pass++;
        if (done_id !== 2'd0) $display("FAIL single_id got %0d want 0", done_id); else pass++;
        if (hit_count !== 4'd2) $display("FAIL single_hits got %0d want 2", hit_count); else pass++;
    endtask

    task automatic test_overlap();
        logic [7:0] w[2] = '{8'b1011_0110, 8'h00};
        int h[2] = '{2, 0};
        int tg, td;
        bit got;
        for (int k = 0; k < 2; k++) begin
            submit(2, w[k]);
            wait_gnt(got, tg);
            drop(2);
            wait_done(got, td);
            total += 2;
            if (!got || done_id !== 2'd2) $display("FAIL overlap_id got %0d want 2", done_id); else pass++;
            if (hit_count !== 4'(h[k])) $display("FAIL overlap_hits got %0d want %0d", hit_count, h[k]); else pass++;
        end
    endtask

    task automatic test_boundary();
        int tg, td;
        bit got;
        submit(1, 8'b0000_1011);
        wait_gnt(got, tg);
        drop(1);
        wait_done(got, td);
        total += 2;
        if (!got || done_id !== 2'd1) $display("FAIL bound_id got %0d want 1", done_id); else pass++;
        if (hit_count !== 4'd1) $display("FAIL bound_hits got %0d want 1", hit_count); else pass++;
    endtask

    task automatic test_reset_mid();
        int tg, td;
        bit got;
        bit seen = 1'b0;
        submit(3, 8'hFF);
        wait_gnt(got, tg);
        total++;
        if (!got || gnt !== 4'b1000) $display("FAIL mid_gnt got %b want 1000", gnt); else pass++;
        @(posedge clock); #1;
        req_data[15:8] = 8'hBB;
        req[1] = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back('{id: 1, hits: ref_hits(8'hBB)});
        repeat (2) begin
            @(negedge clock);
            total += 3;
            if (det_clear !== 1'b1) $display("FAIL mid_clear got %b want 1", det_clear); else pass++;
            if (done !== 1'b0) $display("FAIL mid_done got %b want 0", done); else pass++;
            if (gnt !== 4'b0) $display("FAIL mid_rst_gnt got %b want 0", gnt); else pass++;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            total++;
            if (done !== 1'b0) $display("FAIL mid_no_done got %b want 0", done); else pass++;
            if (|gnt) seen = 1'b1;
        end
        total++;
        if (!seen || gnt !== 4'b0010) $display("FAIL mid_regrant got %b want 0010", gnt); else pass++;
        @(posedge clock); #1;
        req = 4'b0;
        wait_done(got, td);
        total += 2;
        if (!got || done_id !== 2'd1) $display("FAIL mid_id got %0d want 1", done_id); else pass++;
        if (hit_count !== 4'd2) $display("FAIL mid_hits got %0d want 2", hit_count); else pass++;
    endtask

    initial begin
        reset = 1'b1;
        req = 4'b0;
        req_data = 32'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_overlap();
        test_boundary();
        test_reset_mid();
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
